dcache_assoc_controller: RTL and testbench

//  Control FSM for an N-way set-associative, write-back, write-allocate L1 data cache.

---
 rtl/dcache_assoc_controller_if.sv | 69 ++++++
 rtl/dcache_assoc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_assoc_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_assoc_controller_if.sv
// Request, L2 and datapath-control bundle around the dcache controller.
// master = controller side; slave = pipeline/L2/datapath side. DCACHE_PERF_COUNTERS_EN adds counters.
package dcache_pkg;
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        STORE   = 2'd1,
        CLFLUSH = 2'd2
    } memory_operation_e;
endpackage

interface dcache_assoc_controller_if #(
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
);
    import dcache_pkg::*;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int OFS_W = $clog2(WORDS_PER_LINE);

    logic                 pipe_req_valid;
    memory_operation_e    pipe_req_type;
    logic                 pipe_req_fulfilled;
    logic                 l2_req_valid;
    memory_operation_e    l2_req_type;
    logic                 l2_req_fulfilled;
    logic [NUM_WAYS-1:0]  way_match;
    logic [NUM_WAYS-1:0]  way_valid;
    logic [NUM_WAYS-1:0]  way_dirty;
    logic [WAY_W-1:0]     sel_way;
    logic [OFS_W-1:0]     word_offset;
    logic                 flush_mode;
    logic                 load_mode;
    logic                 perform_write;
    logic                 set_selected_dirty_bit;
    logic                 clear_selected_dirty_bit;
    logic                 clear_selected_valid_bit;
    logic                 set_new_l2_block_address;
    logic                 use_dirty_tag_for_l2_block_address;
    logic                 finish_new_line_install;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;
`endif

    modport master (
        input  pipe_req_valid, pipe_req_type, l2_req_fulfilled,
               way_match, way_valid, way_dirty,
        output pipe_req_fulfilled, l2_req_valid, l2_req_type, sel_way, word_offset,
               flush_mode, load_mode, perform_write, set_selected_dirty_bit,
               clear_selected_dirty_bit, clear_selected_valid_bit,
               set_new_l2_block_address, use_dirty_tag_for_l2_block_address,
               finish_new_line_install
`ifdef DCACHE_PERF_COUNTERS_EN
        , hit_count, miss_count
`endif
    );

    modport slave (
        output pipe_req_valid, pipe_req_type, l2_req_fulfilled,
               way_match, way_valid, way_dirty,
        input  pipe_req_fulfilled, l2_req_valid, l2_req_type, sel_way, word_offset,
               flush_mode, load_mode, perform_write, set_selected_dirty_bit,
               clear_selected_dirty_bit, clear_selected_valid_bit,
               set_new_l2_block_address, use_dirty_tag_for_l2_block_address,
               finish_new_line_install
`ifdef DCACHE_PERF_COUNTERS_EN
        , hit_count, miss_count
`endif
    );
endinterface

// File: rtl/dcache_assoc_controller.sv
// N-way write-back/write-allocate L1 D-cache control FSM: hits complete same cycle, misses/flushes walk line beats.
// Beats advance only on l2_req_fulfilled (request held otherwise); DCACHE_PERF_COUNTERS_EN adds hit/miss counters.
module dcache_assoc_controller
    import dcache_pkg::*;
#(
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic clk,
    input  logic reset,
    dcache_assoc_controller_if.master bus
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int OFS_W = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FLUSH} state_e;

    state_e           state;
    logic [WAY_W-1:0] rr_ptr;
    logic [WAY_W-1:0] victim_q;
    logic             from_rr_q;
    logic [OFS_W-1:0] beat;

    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             hit;
    logic             all_valid;
    logic             hit_dirty;
    logic             victim_dirty;
    logic             is_flush;
    logic             done;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit_way = '0;
        victim  = rr_ptr;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.way_match[i]) hit_way = WAY_W'(i);
            if (!bus.way_valid[i]) victim = WAY_W'(i);
        end
    end

    assign hit          = |bus.way_match;
    assign all_valid    = &bus.way_valid;
    assign hit_dirty    = bus.way_dirty[hit_way];
    assign victim_dirty = bus.way_valid[victim] && bus.way_dirty[victim];
    assign is_flush     = (bus.pipe_req_type == CLFLUSH);
    assign done         = bus.l2_req_fulfilled && (beat == OFS_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            victim_q  <= '0;
            from_rr_q <= 1'b0;
            beat      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pipe_req_valid) begin
                        if (is_flush) begin
                            if (hit && hit_dirty) begin
                                victim_q  <= hit_way;
                                from_rr_q <= 1'b0;
                                beat      <= '0;
                                state     <= FLUSH;
                            end
                        end else if (!hit) begin
                            victim_q  <= victim;
                            from_rr_q <= all_valid;
                            beat      <= '0;
                            state     <= victim_dirty ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK, ALLOCATE, FLUSH: begin
                    if (bus.l2_req_fulfilled) beat <= beat + OFS_W'(1);
                    if (done) begin
                        beat <= '0;
                        if (state == WRITEBACK) begin
                            state <= ALLOCATE;
                        end else begin
                            state <= IDLE;
                            if (state == ALLOCATE && from_rr_q)
                                rr_ptr <= (NUM_WAYS > 1) ? rr_ptr + WAY_W'(1) : '0;
                        end
                    end
                end
                default: state <= state_e'(2'bxx);
            endcase
        end
    end

    always_comb begin
        bus.pipe_req_fulfilled                 = 1'b0;
        bus.l2_req_valid                       = 1'b0;
        bus.l2_req_type                        = LOAD;
        bus.sel_way                            = victim_q;
        bus.word_offset                        = beat;
        bus.flush_mode                         = 1'b0;
        bus.load_mode                          = 1'b0;
        bus.perform_write                      = 1'b0;
        bus.set_selected_dirty_bit             = 1'b0;
        bus.clear_selected_dirty_bit           = 1'b0;
        bus.clear_selected_valid_bit           = 1'b0;
        bus.set_new_l2_block_address           = 1'b0;
        bus.use_dirty_tag_for_l2_block_address = 1'b0;
        bus.finish_new_line_install            = 1'b0;
        case (state)
            IDLE: begin
                bus.sel_way = hit ? hit_way : victim;
                if (bus.pipe_req_valid) begin
                    if (is_flush) begin
                        if (!hit) begin
                            bus.pipe_req_fulfilled = 1'b1;
                        end else if (!hit_dirty) begin
                            bus.clear_selected_valid_bit = 1'b1;
                            bus.pipe_req_fulfilled       = 1'b1;
                        end else begin
                            bus.set_new_l2_block_address           = 1'b1;
                            bus.use_dirty_tag_for_l2_block_address = 1'b1;
                        end
                    end else if (hit) begin
                        bus.pipe_req_fulfilled = 1'b1;
                        if (bus.pipe_req_type == STORE) begin
                            bus.perform_write          = 1'b1;
                            bus.set_selected_dirty_bit = 1'b1;
                        end
                    end else begin
                        bus.set_new_l2_block_address           = 1'b1;
                        bus.use_dirty_tag_for_l2_block_address = victim_dirty;
                    end
                end
            end
            WRITEBACK, FLUSH: begin
                bus.l2_req_valid = 1'b1;
                bus.l2_req_type  = STORE;
                bus.flush_mode   = 1'b1;
                if (done) begin
                    bus.clear_selected_dirty_bit = 1'b1;
                    bus.clear_selected_valid_bit = 1'b1;
                    if (state == WRITEBACK) bus.set_new_l2_block_address = 1'b1;
                    else                    bus.pipe_req_fulfilled       = 1'b1;
                end
            end
            ALLOCATE: begin
                bus.l2_req_valid  = 1'b1;
                bus.l2_req_type   = LOAD;
                bus.load_mode     = 1'b1;
                bus.perform_write = bus.l2_req_fulfilled;
                if (done) begin
                    bus.finish_new_line_install  = 1'b1;
                    bus.clear_selected_dirty_bit = 1'b1;
                end
            end
            default: begin
                bus.pipe_req_fulfilled                 = 1'bx;
                bus.l2_req_valid                       = 1'bx;
                bus.l2_req_type                        = memory_operation_e'(2'bxx);
                bus.sel_way                            = 'x;
                bus.word_offset                        = 'x;
                bus.flush_mode                         = 1'bx;
                bus.load_mode                          = 1'bx;
                bus.perform_write                      = 1'bx;
                bus.set_selected_dirty_bit             = 1'bx;
                bus.clear_selected_dirty_bit           = 1'bx;
                bus.clear_selected_valid_bit           = 1'bx;
                bus.set_new_l2_block_address           = 1'bx;
                bus.use_dirty_tag_for_l2_block_address = 1'bx;
                bus.finish_new_line_install            = 1'bx;
            end
        endcase
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic        replay_q;

    // The cycle after a line install is the replayed request; it is not a fresh hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q    <= '0;
            miss_q   <= '0;
            replay_q <= 1'b0;
        end else begin
            replay_q <= (state == ALLOCATE) && done;
            if (state == IDLE && bus.pipe_req_valid && !is_flush) begin
                if (hit && !replay_q && hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
                if (!hit && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
`endif

    assert property (@(posedge clk) disable iff (reset) $onehot0(bus.way_match));
endmodule

// File: tb/tb_dcache_assoc_controller.sv
// Directed bench: a set-level model builds per-cycle input/expected-output records that are replayed and compared.
module tb_dcache_assoc_controller;
    import dcache_pkg::*;
    localparam int NW = 2;
    localparam int WPL = 4;

    typedef struct packed {
        logic              ful;
        logic              l2v;
        memory_operation_e l2t;
        logic [0:0]        sel;
        logic [1:0]        off;
        logic              flush;
        logic              load;
        logic              pw;
        logic              setd;
        logic              clrd;
        logic              clrv;
        logic              setaddr;
        logic              usedirty;
        logic              finish;
    } exp_t;

    typedef struct packed {
        logic              rst;
        logic              chk;
        logic              rv;
        memory_operation_e rtype;
        logic              l2f;
        logic [1:0]        match;
        logic [1:0]        valid;
        logic [1:0]        dirty;
        exp_t              e;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dcache_assoc_controller_if #(.NUM_WAYS(NW), .WORDS_PER_LINE(WPL)) ifc ();
    dcache_assoc_controller #(.NUM_WAYS(NW), .WORDS_PER_LINE(WPL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    rec_t  q[$];
    logic [1:0] m_valid, m_dirty;
    int    m_rr, m_hits, m_misses;
    int    n_vec, n_bad;
    string tag;

    function automatic int victim_of();
        int v;
        v = m_rr;
        for (int i = NW - 1; i >= 0; i--) if (!m_valid[i]) v = i;
        return v;
    endfunction

    function automatic rec_t base(logic rv, memory_operation_e t);
        rec_t r;
        r       = '0;
        r.chk   = 1'b1;
        r.rv    = rv;
        r.rtype = t;
        r.valid = m_valid;
        r.dirty = m_dirty;
        r.e.l2t = LOAD;
        return r;
    endfunction

    // kind: 0 writeback, 1 allocate, 2 flush
    task automatic beats(int way, int kind, int stall, memory_operation_e t);
        rec_t r;
        for (int b = 0; b < WPL; b++) begin
            for (int s = 0; s < ((b > 0) ? stall : 0); s++) begin
                r = base(1'b1, t);
                r.e.l2v = 1'b1;
                r.e.l2t = (kind == 1) ? LOAD : STORE;
                r.e.sel = 1'(way);
                r.e.off = 2'(b);
                if (kind == 1) r.e.load = 1'b1; else r.e.flush = 1'b1;
                q.push_back(r);
            end
            r = base(1'b1, t);
            r.l2f = 1'b1;
            r.e.l2v = 1'b1;
            r.e.l2t = (kind == 1) ? LOAD : STORE;
            r.e.sel = 1'(way);
            r.e.off = 2'(b);
            if (kind == 1) begin r.e.load = 1'b1; r.e.pw = 1'b1; end
            else r.e.flush = 1'b1;
            if (b == WPL - 1) begin
                r.e.clrd = 1'b1;
                if (kind == 0) begin r.e.clrv = 1'b1; r.e.setaddr = 1'b1; end
                if (kind == 1) r.e.finish = 1'b1;
                if (kind == 2) begin r.e.clrv = 1'b1; r.e.ful = 1'b1; end
            end
            q.push_back(r);
        end
    endtask

    // Builds the whole cycle sequence for one pipeline request, then one idle gap cycle.
    task automatic req(memory_operation_e t, int hit, int stall);
        rec_t r;
        int   v;
        bit   from_rr, vdirty;
        r = base(1'b1, t);
        if (hit >= 0) r.match = 2'(1 << hit);
        if (t != CLFLUSH) begin
            if (hit >= 0) begin
                r.e.ful = 1'b1;
                r.e.sel = 1'(hit);
                if (t == STORE) begin r.e.pw = 1'b1; r.e.setd = 1'b1; m_dirty[hit] = 1'b1; end
                q.push_back(r);
                m_hits++;
            end else begin
                v       = victim_of();
                from_rr = (m_valid == 2'b11);
                vdirty  = m_valid[v] && m_dirty[v];
                r.e.sel = 1'(v);
                r.e.setaddr = 1'b1;
                r.e.usedirty = vdirty;
                q.push_back(r);
                m_misses++;
                if (vdirty) begin
                    beats(v, 0, stall, t);
                    m_valid[v] = 1'b0;
                    m_dirty[v] = 1'b0;
                end
                beats(v, 1, stall, t);
                m_valid[v] = 1'b1;
                m_dirty[v] = 1'b0;
                if (from_rr) m_rr = (m_rr + 1) % NW;
                r = base(1'b1, t);
                r.match = 2'(1 << v);
                r.e.ful = 1'b1;
                r.e.sel = 1'(v);
                if (t == STORE) begin r.e.pw = 1'b1; r.e.setd = 1'b1; m_dirty[v] = 1'b1; end
                q.push_back(r);
            end
        end else begin
            if (hit < 0) begin
                r.e.ful = 1'b1;
                r.e.sel = 1'(victim_of());
                q.push_back(r);
            end else if (!m_dirty[hit]) begin
                r.e.ful = 1'b1;
                r.e.clrv = 1'b1;
                r.e.sel = 1'(hit);
                q.push_back(r);
                m_valid[hit] = 1'b0;
            end else begin
                r.e.sel = 1'(hit);
                r.e.setaddr = 1'b1;
                r.e.usedirty = 1'b1;
                q.push_back(r);
                beats(hit, 2, stall, t);
                m_valid[hit] = 1'b0;
                m_dirty[hit] = 1'b0;
            end
        end
        r = base(1'b0, LOAD);
        r.e.sel = 1'(victim_of());
        q.push_back(r);
    endtask

    task automatic chk_val(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(rec_t r);
        exp_t got;
        @(posedge clk);
        #1;
        reset                = r.rst;
        ifc.pipe_req_valid   = r.rv;
        ifc.pipe_req_type    = r.rtype;
        ifc.l2_req_fulfilled = r.l2f;
        ifc.way_match        = r.match;
        ifc.way_valid        = r.valid;
        ifc.way_dirty        = r.dirty;
        @(negedge clk);
        if (r.chk) begin
            got.ful      = ifc.pipe_req_fulfilled;
            got.l2v      = ifc.l2_req_valid;
            got.l2t      = ifc.l2_req_type;
            got.sel      = ifc.sel_way;
            got.off      = ifc.word_offset;
            got.flush    = ifc.flush_mode;
            got.load     = ifc.load_mode;
            got.pw       = ifc.perform_write;
            got.setd     = ifc.set_selected_dirty_bit;
            got.clrd     = ifc.clear_selected_dirty_bit;
            got.clrv     = ifc.clear_selected_valid_bit;
            got.setaddr  = ifc.set_new_l2_block_address;
            got.usedirty = ifc.use_dirty_tag_for_l2_block_address;
            got.finish   = ifc.finish_new_line_install;
            n_vec++;
            if (got !== r.e) begin
                n_bad++;
                $display("FAIL vec %0d (%s): outputs got %h want %h", n_vec, tag, got, r.e);
            end
        end
    endtask

    task automatic run_q();
        while (q.size() > 0) step(q.pop_front());
    endtask

    initial begin
        rec_t r;
        int   sz;
        n_vec = 0; n_bad = 0;
        m_valid = 2'b00; m_dirty = 2'b00; m_rr = 0; m_hits = 0; m_misses = 0;
        ifc.pipe_req_valid = 1'b0; ifc.pipe_req_type = LOAD; ifc.l2_req_fulfilled = 1'b0;
        ifc.way_match = '0; ifc.way_valid = '0; ifc.way_dirty = '0;

        tag = "reset";
        r = base(1'b0, LOAD); r.rst = 1'b1; r.chk = 1'b0;
        q.push_back(r); q.push_back(r);
        q.push_back(base(1'b0, LOAD));
        run_q();

        tag = "load_hit";
        m_valid = 2'b10;
        req(LOAD, 1, 0);
        chk_val("s1_cycles", q.size(), 2);
        run_q();

        tag = "store_alloc";
        m_valid = 2'b01; m_dirty = 2'b00;
        req(STORE, -1, 0);
        chk_val("s2_cycles", q.size(), 7);
        chk_val("s2_rr", m_rr, 0);
        run_q();

        tag = "load_wb_alloc";
        m_valid = 2'b11; m_dirty = 2'b11;
        req(LOAD, -1, 0);
        chk_val("s3_cycles", q.size(), 11);
        chk_val("s3_rr", m_rr, 1);
        run_q();
`ifdef DCACHE_PERF_COUNTERS_EN
        chk_val("hit_count", int'(ifc.hit_count), m_hits);
        chk_val("miss_count", int'(ifc.miss_count), m_misses);
        chk_val("model_hits", m_hits, 1);
        chk_val("model_misses", m_misses, 2);
`endif

        tag = "clflush_dirty";
        m_valid = 2'b11; m_dirty = 2'b01;
        sz = q.size();
        req(CLFLUSH, 0, 1);
        chk_val("s4_cycles", q.size() - sz, 9);
        run_q();

        tag = "clflush_miss";
        req(CLFLUSH, -1, 0);
        tag = "clflush_clean";
        req(CLFLUSH, 1, 0);
        run_q();
        tag = "store_alloc_stall";
        req(STORE, -1, 2);
        tag = "store_hit";
        req(STORE, 0, 0);
        chk_val("extra_rr", m_rr, 1);
        run_q();

        tag = "reset_mid_alloc";
        m_valid = 2'b01; m_dirty = 2'b00;
        r = base(1'b1, LOAD); r.e.sel = 1'b1; r.e.setaddr = 1'b1;
        q.push_back(r);
        r = base(1'b1, LOAD); r.l2f = 1'b1;
        r.e.l2v = 1'b1; r.e.load = 1'b1; r.e.pw = 1'b1; r.e.sel = 1'b1; r.e.off = 2'd0;
        q.push_back(r);
        r.rst = 1'b1; r.e.off = 2'd1;
        q.push_back(r);
        m_valid = 2'b00;
        q.push_back(base(1'b0, LOAD));
        run_q();
        m_rr = 0; m_hits = 0; m_misses = 0;
`ifdef DCACHE_PERF_COUNTERS_EN
        chk_val("hit_count_rst", int'(ifc.hit_count), 0);
        chk_val("miss_count_rst", int'(ifc.miss_count), 0);
`endif

        tag = "rr_after_reset";
        m_valid = 2'b11; m_dirty = 2'b00;
        req(LOAD, -1, 0);
        chk_val("post_rst_rr", m_rr, 1);
        run_q();

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
